// File: rtl/xor_rmw_update_pipe.sv
// xor_rmw_update_pipe
//   Read-modify-write XOR update pipeline for the URAM-resident hash table.
//   A request is accepted into S1 (read address registered), the row arrives
//   in S2 two cycles after accept, where it is merged with the operands the
//   external DFU_URAM hazard unit selects. The update is then XORed in, the
//   result is held in WR0, and it is committed from WR1. The block also owns
//   table initialisation: a zero-fill FSM that runs after reset and on request.
//
// Ports
//   clk, reset                      clock, synchronous active-high reset
//   i_in_valid/o_in_ready           request handshake (ready only in RUN)
//   i_in_index/i_in_xor/i_in_mask   row, per-lane XOR operand, lane enable
//   i_clear_req                     zero-fill request (level, sampled in RUN)
//   o_busy, o_clear_done            FSM not in RUN / zero-fill complete pulse
//   o_rd_index, o_arbiter_result    S1 index / S2 lane mask, to DFU
//   o_write_reg_0_*, o_write_reg_1_* WR0 / WR1 index and valid, to DFU
//   o_write_reg_11_xor              WR1 row delayed one cycle, to DFU
//   i_update_result_senior_1/2/3    DFU per-lane forwarding selects
//   i_write_reg_help_xor            forwarded row for senior_2
//   i_write_help_xor_senior_3_out   forwarded row for senior_3
//   o_out_valid/o_out_index/o_out_data  row committed to URAM this cycle
module xor_rmw_update_pipe #(
  parameter int NUM_MUL     = 4,
  parameter int INDEX_WIDTH = 12,
  parameter int DATA_WIDTH  = 64
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            i_in_valid,
  output logic                            o_in_ready,
  input  logic [INDEX_WIDTH-1:0]          i_in_index,
  input  logic [NUM_MUL*DATA_WIDTH-1:0]   i_in_xor,
  input  logic [NUM_MUL-1:0]              i_in_mask,
  input  logic                            i_clear_req,
  output logic                            o_busy,
  output logic                            o_clear_done,
  output logic [INDEX_WIDTH-1:0]          o_rd_index,
  output logic [NUM_MUL-1:0]              o_arbiter_result,
  output logic [INDEX_WIDTH-1:0]          o_write_reg_0_index,
  output logic                            o_write_reg_0_valid,
  output logic [INDEX_WIDTH-1:0]          o_write_reg_1_index,
  output logic                            o_write_reg_1_valid,
  output logic [NUM_MUL*DATA_WIDTH-1:0]   o_write_reg_11_xor,
  input  logic [NUM_MUL-1:0]              i_update_result_senior_1,
  input  logic [NUM_MUL-1:0]              i_update_result_senior_2,
  input  logic [NUM_MUL-1:0]              i_update_result_senior_3,
  input  logic [NUM_MUL*DATA_WIDTH-1:0]   i_write_reg_help_xor,
  input  logic [NUM_MUL*DATA_WIDTH-1:0]   i_write_help_xor_senior_3_out,
  output logic                            o_out_valid,
  output logic [INDEX_WIDTH-1:0]          o_out_index,
  output logic [NUM_MUL*DATA_WIDTH-1:0]   o_out_data
);

  localparam int ROW_W = NUM_MUL * DATA_WIDTH;
  localparam int DEPTH = 1 << INDEX_WIDTH;

  localparam logic [1:0] ST_CLEAR = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  // Lane-sliced merge: pick the youngest in-flight copy of each lane (strict
  // priority senior_1 > senior_2 > senior_3 > URAM), then XOR enabled lanes.
  function automatic logic [ROW_W-1:0] merge_row(
    input logic [ROW_W-1:0]   ram_row,
    input logic [ROW_W-1:0]   fwd1,
    input logic [ROW_W-1:0]   fwd2,
    input logic [ROW_W-1:0]   fwd3,
    input logic [NUM_MUL-1:0] sel1,
    input logic [NUM_MUL-1:0] sel2,
    input logic [NUM_MUL-1:0] sel3,
    input logic [NUM_MUL-1:0] mask,
    input logic [ROW_W-1:0]   xor_op
  );
    logic [ROW_W-1:0]      res;
    logic [DATA_WIDTH-1:0] old;
    res = '0;
    for (int l = 0; l < NUM_MUL; l++) begin
      if (sel1[l])      old = fwd1[l*DATA_WIDTH +: DATA_WIDTH];
      else if (sel2[l]) old = fwd2[l*DATA_WIDTH +: DATA_WIDTH];
      else if (sel3[l]) old = fwd3[l*DATA_WIDTH +: DATA_WIDTH];
      else              old = ram_row[l*DATA_WIDTH +: DATA_WIDTH];
      res[l*DATA_WIDTH +: DATA_WIDTH] =
        mask[l] ? (old ^ xor_op[l*DATA_WIDTH +: DATA_WIDTH]) : old;
    end
    return res;
  endfunction

  logic [1:0]             r_state;
  logic [INDEX_WIDTH-1:0] r_clr_cnt;
  logic                   r_clear_done;

  logic                   r_vld_p1, r_vld_p2, r_vld_p3, r_vld_p4;
  logic [INDEX_WIDTH-1:0] r_index_p1, r_index_p2, r_index_p3, r_index_p4;
  logic [ROW_W-1:0]       r_xor_p1, r_xor_p2;
  logic [NUM_MUL-1:0]     r_mask_p1, r_mask_p2;
  logic [ROW_W-1:0]       r_row_p2, r_data_p3, r_data_p4;
  logic [ROW_W-1:0]       r_data_p5;

  logic [ROW_W-1:0]       r_mem [DEPTH];

  logic                   w_accept;
  logic [ROW_W-1:0]       w_merged_p2;

  assign o_in_ready = (r_state == ST_RUN);
  assign o_busy     = (r_state != ST_RUN);
  assign w_accept   = i_in_valid && o_in_ready;

  assign w_merged_p2 = merge_row(r_row_p2, r_data_p3, i_write_reg_help_xor,
                                 i_write_help_xor_senior_3_out,
                                 i_update_result_senior_1, i_update_result_senior_2,
                                 i_update_result_senior_3, r_mask_p2, r_xor_p2);

  // Control: FSM, clear counter and stage valids
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_CLEAR;
      r_clr_cnt    <= '0;
      r_clear_done <= 1'b0;
      r_vld_p1     <= 1'b0;
      r_vld_p2     <= 1'b0;
      r_vld_p3     <= 1'b0;
      r_vld_p4     <= 1'b0;
    end else begin
      r_clear_done <= 1'b0;
      case (r_state)
        ST_CLEAR: begin
          r_clr_cnt <= r_clr_cnt + 1'b1;
          if (r_clr_cnt == {INDEX_WIDTH{1'b1}}) begin
            r_state      <= ST_RUN;
            r_clear_done <= 1'b1;
          end
        end
        ST_RUN: begin
          if (i_clear_req) r_state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          // Start zero-fill only once WR1 has retired, so the single URAM
          // write port is never shared with a pipeline commit.
          if (!(r_vld_p1 || r_vld_p2 || r_vld_p3 || r_vld_p4)) begin
            r_state   <= ST_CLEAR;
            r_clr_cnt <= '0;
          end
        end
        default: r_state <= ST_CLEAR;
      endcase
      r_vld_p1 <= w_accept;
      r_vld_p2 <= r_vld_p1;
      r_vld_p3 <= r_vld_p2;
      r_vld_p4 <= r_vld_p3;
    end
  end

  // S1: request captured, URAM read address registered
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_index_p1 <= i_in_index;
      r_xor_p1   <= i_in_xor;
      r_mask_p1  <= i_in_mask;
    end
  end

  // S2: URAM row valid (read-first against a same-cycle write)
  always_ff @(posedge clk) begin
    r_index_p2 <= r_index_p1;
    r_xor_p2   <= r_xor_p1;
    r_mask_p2  <= r_mask_p1;
    r_row_p2   <= r_mem[r_index_p1];
  end

  // WR0 / WR1: merged row, then commit
  always_ff @(posedge clk) begin
    r_index_p3 <= r_index_p2;
    r_data_p3  <= w_merged_p2;
    r_index_p4 <= r_index_p3;
    r_data_p4  <= r_data_p3;
  end

  // WR1 delayed one cycle covers the URAM read-first window for the DFU
  always_ff @(posedge clk) begin
    if (reset) r_data_p5 <= '0;
    else       r_data_p5 <= r_data_p4;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (r_state == ST_CLEAR) r_mem[r_clr_cnt]  <= '0;
      else if (r_vld_p4)       r_mem[r_index_p4] <= r_data_p4;
    end
  end

  assign o_clear_done        = r_clear_done;
  assign o_rd_index          = r_index_p1;
  assign o_arbiter_result    = r_mask_p2;
  assign o_write_reg_0_index = r_index_p3;
  assign o_write_reg_0_valid = r_vld_p3;
  assign o_write_reg_1_index = r_index_p4;
  assign o_write_reg_1_valid = r_vld_p4;
  assign o_write_reg_11_xor  = r_data_p5;
  assign o_out_valid         = r_vld_p4;
  assign o_out_index         = r_index_p4;
  assign o_out_data          = r_data_p4;

endmodule

// File: tb/tb_xor_rmw_update_pipe.sv
// Testbench for xor_rmw_update_pipe (NUM_MUL=4, DATA_WIDTH=64, INDEX_WIDTH=4).
// Includes a small behavioural DFU_URAM hazard unit that derives the
// forwarding selects from the DUT's stage indices/valids, a sequential
// reference table, and a commit scoreboard.
module tb_xor_rmw_update_pipe;
  localparam int NM = 4;
  localparam int IW = 4;
  localparam int DW = 64;
  localparam int RW = NM * DW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          i_in_valid = 1'b0;
  logic          o_in_ready;
  logic [IW-1:0] i_in_index = '0;
  logic [RW-1:0] i_in_xor = '0;
  logic [NM-1:0] i_in_mask = '0;
  logic          i_clear_req = 1'b0;
  logic          o_busy, o_clear_done;
  logic [IW-1:0] o_rd_index;
  logic [NM-1:0] o_arbiter_result;
  logic [IW-1:0] o_write_reg_0_index, o_write_reg_1_index;
  logic          o_write_reg_0_valid, o_write_reg_1_valid;
  logic [RW-1:0] o_write_reg_11_xor;
  logic [NM-1:0] sel1, sel2, sel3;
  logic [RW-1:0] help_xor, senior3_xor;
  logic          o_out_valid;
  logic [IW-1:0] o_out_index;
  logic [RW-1:0] o_out_data;

  xor_rmw_update_pipe #(.NUM_MUL(NM), .INDEX_WIDTH(IW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset),
    .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
    .i_in_index(i_in_index), .i_in_xor(i_in_xor), .i_in_mask(i_in_mask),
    .i_clear_req(i_clear_req), .o_busy(o_busy), .o_clear_done(o_clear_done),
    .o_rd_index(o_rd_index), .o_arbiter_result(o_arbiter_result),
    .o_write_reg_0_index(o_write_reg_0_index), .o_write_reg_0_valid(o_write_reg_0_valid),
    .o_write_reg_1_index(o_write_reg_1_index), .o_write_reg_1_valid(o_write_reg_1_valid),
    .o_write_reg_11_xor(o_write_reg_11_xor),
    .i_update_result_senior_1(sel1), .i_update_result_senior_2(sel2),
    .i_update_result_senior_3(sel3),
    .i_write_reg_help_xor(help_xor), .i_write_help_xor_senior_3_out(senior3_xor),
    .o_out_valid(o_out_valid), .o_out_index(o_out_index), .o_out_data(o_out_data)
  );

  always #5 clk = ~clk;

  // Behavioural DFU: S2 index is the S1 index one cycle later; the senior_3
  // window is WR1 one cycle later. Selects cover every lane because masked-off
  // lanes are written back too.
  logic [IW-1:0] dfu_s2_idx, dfu_wr1d_idx;
  logic          dfu_wr1d_v;
  always @(posedge clk) begin
    dfu_s2_idx   <= o_rd_index;
    dfu_wr1d_idx <= o_write_reg_1_index;
    dfu_wr1d_v   <= reset ? 1'b0 : o_write_reg_1_valid;
  end
  assign sel1 = (o_write_reg_0_valid && o_write_reg_0_index == dfu_s2_idx) ? '1 : '0;
  assign sel2 = (o_write_reg_1_valid && o_write_reg_1_index == dfu_s2_idx) ? '1 : '0;
  assign sel3 = (dfu_wr1d_v && dfu_wr1d_idx == dfu_s2_idx) ? '1 : '0;
  assign help_xor    = o_out_data;
  assign senior3_xor = o_write_reg_11_xor;

  typedef struct {
    logic [IW-1:0] idx;
    logic [RW-1:0] data;
  } exp_t;

  exp_t          sb[$];
  exp_t          mon_e;
  logic [RW-1:0] ref_mem [16];
  logic [RW-1:0] last_data = '0;
  int            checks = 0;
  int            failures = 0;
  int            n_commits = 0;

  task automatic check_val(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  task automatic zero_ref();
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
  endtask

  function automatic logic [RW-1:0] rnd_row();
    logic [RW-1:0] r;
    for (int i = 0; i < RW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Drive one request for one cycle; expected commit is the sequential result.
  task automatic send(input logic [IW-1:0] idx, input logic [RW-1:0] x, input logic [NM-1:0] m);
    logic [RW-1:0] r;
    r = ref_mem[idx];
    for (int l = 0; l < NM; l++)
      if (m[l]) r[l*DW +: DW] = r[l*DW +: DW] ^ x[l*DW +: DW];
    ref_mem[idx] = r;
    sb.push_back('{idx, r});
    i_in_valid = 1'b1;
    i_in_index = idx;
    i_in_xor   = x;
    i_in_mask  = m;
    @(posedge clk);
    #1;
    i_in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_clear(output int busy_cyc, output logic done);
    busy_cyc = 0;
    done = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (o_busy) busy_cyc++;
      else begin
        done = o_clear_done;
        break;
      end
    end
  endtask

  always @(negedge clk) begin
    if (o_out_valid) begin
      n_commits++;
      last_data = o_out_data;
      if (sb.size() == 0) check_val("unexpected_commit", 1, 0);
      else begin
        mon_e = sb.pop_front();
        check_val("commit_idx", RW'(o_out_index), RW'(mon_e.idx));
        check_val("commit_data", o_out_data, mon_e.data);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int            bc;
    logic          done;
    int            lat;
    int            base;
    logic [DW-1:0] a, b, c, d;

    zero_ref();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_out_valid", RW'(o_out_valid), 0);
    check_val("rst_in_ready", RW'(o_in_ready), 0);
    check_val("rst_busy", RW'(o_busy), 1);
    check_val("rst_clear_done", RW'(o_clear_done), 0);
    check_val("rst_wr11", o_write_reg_11_xor, '0);
    reset = 1'b0;

    wait_clear(bc, done);
    check_val("init_busy_cycles", RW'(bc), 16);
    check_val("init_clear_done", RW'(done), 1);
    check_val("init_in_ready", RW'(o_in_ready), 1);
    @(negedge clk);
    check_val("clear_done_pulse", RW'(o_clear_done), 0);

    // Every row reads back zero (mask 0 writes the row back unchanged)
    for (int i = 0; i < 16; i++) send(IW'(i), rnd_row(), 4'h0);
    idle(6);

    // Single op with latency measurement
    send(4'd3, {64'd4, 64'd3, 64'd2, 64'd1}, 4'hF);
    lat = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      lat++;
      if (o_out_valid) break;
    end
    check_val("single_latency", RW'(lat), 4);
    idle(3);
    check_val("single_data", last_data, {64'd4, 64'd3, 64'd2, 64'd1});

    // Back-to-back same index (senior_1 path)
    send(4'd5, RW'(64'd1), 4'h1);
    send(4'd5, RW'(64'd2), 4'h1);
    send(4'd5, RW'(64'd4), 4'h1);
    send(4'd5, RW'(64'd8), 4'h1);
    idle(6);
    check_val("b2b_lane0", last_data, RW'(64'hF));

    // Same index with gaps of 1, 2 and 3 idle cycles
    send(4'd7, rnd_row(), 4'hF);
    idle(1);
    send(4'd7, rnd_row(), 4'b1010);
    idle(2);
    send(4'd7, rnd_row(), 4'hF);
    idle(3);
    send(4'd7, rnd_row(), 4'b0110);
    send(4'd7, rnd_row(), 4'hF);
    idle(1);
    send(4'd7, rnd_row(), 4'b0011);
    idle(6);

    // Partial mask on a known row
    a = 64'h0123_4567_89AB_CDEF;
    b = 64'hDEAD_BEEF_0000_1111;
    c = 64'h5555_AAAA_3333_CCCC;
    d = 64'h8000_0000_0000_0001;
    send(4'd9, {d, c, b, a}, 4'hF);
    idle(2);
    send(4'd9, '1, 4'b0101);
    idle(6);
    check_val("mask_0101", last_data, {d, ~c, b, ~a});

    // clear_req with three ops in flight
    base = n_commits;
    send(4'd1, rnd_row(), 4'hF);
    send(4'd2, rnd_row(), 4'hF);
    send(4'd3, rnd_row(), 4'hF);
    i_clear_req = 1'b1;
    @(posedge clk);
    #1;
    i_clear_req = 1'b0;
    check_val("drain_in_ready", RW'(o_in_ready), 0);
    check_val("drain_busy", RW'(o_busy), 1);
    zero_ref();
    wait_clear(bc, done);
    check_val("drain_commits", RW'(n_commits - base), 3);
    check_val("drain_clear_done", RW'(done), 1);
    send(4'd1, rnd_row(), 4'h0);
    send(4'd2, rnd_row(), 4'h0);
    idle(6);

    // Reset two cycles after accept drops the op
    base = n_commits;
    send(4'd4, rnd_row(), 4'hF);
    @(posedge clk);
    #1;
    reset = 1'b1;
    sb.delete();
    zero_ref();
    @(posedge clk);
    #1;
    reset = 1'b0;
    wait_clear(bc, done);
    check_val("rst_mid_commits", RW'(n_commits - base), 0);
    check_val("rst_mid_busy_cycles", RW'(bc), 16);
    send(4'd4, rnd_row(), 4'h0);
    idle(6);

    check_val("sb_empty", RW'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
